// File: rtl/serial_adder_if.sv
// Request/response handshake bundle for the bit-serial adder/subtractor.
// master drives requests and consumes results; slave is the adder.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             done_valid;
  logic             done_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start_valid, a, b, sub, done_ready,
    input  start_ready, done_valid, sum, cout, ovf
  );

  modport slave (
    input  start_valid, a, b, sub, done_ready,
    output start_ready, done_valid, sum, cout, ovf
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell plus a registered carry,
// processing one operand bit per clock, LSB first.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input logic           clk,
  input logic           rst_n,
  serial_adder_if.slave bus
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_sh_q, b_sh_q, sum_q;
  logic [CntW-1:0]  cnt_q;
  logic             carry_q, cout_q, ovf_q;
  logic             accept, fa_s, fa_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (bus.start_valid) state_d = StRun;
      StRun:  if (cnt_q == LastBit) state_d = StDone;
      StDone: if (bus.done_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    bus.start_ready = (state_q == StIdle);
    bus.done_valid  = (state_q == StDone);
  end

  assign accept = bus.start_valid && (state_q == StIdle);

  // The single full-adder cell
  always_comb begin
    fa_s = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    fa_c = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));
  end

  // Subtraction is A + ~B + 1: invert B on load and seed the carry with sub.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_sh_q  <= bus.a;
      b_sh_q  <= bus.b ^ {WIDTH{bus.sub}};
      carry_q <= bus.sub;
      cnt_q   <= '0;
    end else if (state_q == StRun) begin
      a_sh_q  <= {1'b0, a_sh_q[WIDTH-1:1]};
      b_sh_q  <= {1'b0, b_sh_q[WIDTH-1:1]};
      sum_q   <= {fa_s, sum_q[WIDTH-1:1]};
      carry_q <= fa_c;
      cnt_q   <= cnt_q + 1'b1;
      if (cnt_q == LastBit) begin
        cout_q <= fa_c;
        ovf_q  <= carry_q ^ fa_c;
      end
    end
  end

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial adder/subtractor for the ALU: adds or subtracts two WIDTH-bit operands one bit per clock through a single `fulladder` instance plus a registered carry. It trades WIDTH cycles of latency for one adder cell. Operands enter through a valid/ready request handshake, and results leave through a valid/ready response handshake. It sits beside the combinational ripple path and serves area-constrained datapaths that feed results to the register write-back stage.

## Interface
- WIDTH, default 8: operand and result width in bits, WIDTH >= 2.
- clk  in  1  the single clock; everything samples on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start_valid  in  1  request valid.
- start_ready  out  1  request ready; high only in IDLE.
- a  in  WIDTH  operand A, sampled on request acceptance.
- b  in  WIDTH  operand B, sampled on request acceptance.
- sub  in  1  0 computes A+B; 1 computes A-B (A + ~B + 1). Sampled on acceptance.
- done_valid  out  1  result valid; high only in DONE.
- done_ready  in  1  result consumer ready.
- sum  out  WIDTH  result bits.
- cout  out  1  carry out of the MSB. With sub=1, 1 means no borrow.
- ovf  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

## Operation
- States:
  - IDLE: start_ready=1.
  - RUN: processes one bit per cycle.
  - DONE: done_valid=1; result held.
- IDLE -> RUN on an edge where start_valid && start_ready. On that edge the block latches:
  - A and (B XOR {WIDTH{sub}}) into shift registers;
  - carry <= sub;
  - bit counter <= 0.
- Each RUN cycle:
  - the fulladder computes (a_sh[0], b_sh[0], carry) -> (s, c);
  - s shifts into sum at the MSB end, while sum shifts right;
  - a_sh and b_sh shift right;
  - carry <= c;
  - the counter increments.
- On the bit-(WIDTH-1) cycle, the block captures the old carry (carry into MSB) for ovf and sets cout <= c.
- RUN -> DONE after the bit-(WIDTH-1) edge.
- DONE -> IDLE on an edge where done_valid && done_ready.
- There is no DONE -> RUN shortcut, because start_ready is low in DONE.
- Operand inputs (a, b, sub) are ignored outside the acceptance edge. Changes during RUN or DONE have no effect.
- start_valid is ignored in RUN and DONE.
- Arithmetic is modulo 2^WIDTH. cout and ovf are the only width-extension information.

## Timing
- Reset values (while rst_n is low, taking effect immediately):
  - state = IDLE, so start_ready = 1;
  - done_valid = 0;
  - sum = 0, cout = 0, ovf = 0;
  - carry and counter = 0.
- Latency: request accepted at edge E0; bits are processed at edges E1..E_WIDTH; done_valid goes high after E_WIDTH.
  - Fixed WIDTH+1 edges from acceptance to result valid, independent of operand values.
- sum, cout and ovf are defined only while done_valid=1. They hold stable through DONE regardless of done_ready.
  - During RUN, sum holds the partial shift state and must not be consumed.
- After the done handshake edge, start_ready=1 in the next cycle. The minimum issue interval is WIDTH+2 cycles.
- Results remain on the outputs after returning to IDLE until the next acceptance begins overwriting sum.
- If rst_n is asserted mid-RUN or mid-DONE:
  - the operation aborts at once and all outputs take their reset values;
  - no done_valid is produced for the aborted operation;
  - the first request accepted after rst_n deassertion completes normally.
- If done_ready is already high when DONE is entered, the transfer completes on the first DONE edge, so done_valid is high for exactly one cycle.

## Test plan
All scenarios use WIDTH=8.
- a=8'h3C, b=8'h42, sub=0 -> sum=8'h7E, cout=0, ovf=0. done_valid rises exactly 9 edges after acceptance.
- a=8'hFF, b=8'h01, sub=0 -> sum=8'h00, cout=1, ovf=0. Also a=8'h7F, b=8'h01 -> sum=8'h80, cout=0, ovf=1.
- a=8'h05, b=8'h07, sub=1 -> sum=8'hFE, cout=0, ovf=0. Also a=8'h80, b=8'h01, sub=1 -> sum=8'h7F, cout=1, ovf=1.
- Backpressure: hold done_ready=0 for 5 cycles after done_valid, while toggling start_valid, a, b and sub -> done_valid and the result stay stable, start_ready stays 0, and no new request is accepted. Releasing done_ready returns to IDLE in 1 edge.
- Back-to-back: keep start_valid and done_ready high with alternating operand pairs -> each result is correct, and acceptances are exactly 10 cycles apart.
- Pull rst_n low during RUN bit 3 -> done_valid=0, sum/cout/ovf=0 and start_ready=1 immediately. Then a=8'h10, b=8'h20, sub=0 after release -> sum=8'h30.
